// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state, width helper and clamp for the ramped PWM generator
package pwm_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int unsigned DEF_PERIOD = 400000;
  function automatic int unsigned width_bits(int unsigned period);
    return $clog2(period + 1);
  endfunction
  localparam int unsigned WIDTH_W = width_bits(DEF_PERIOD);
  function automatic int unsigned clamp(int unsigned raw, int unsigned lo, int unsigned hi);
    return raw > hi ? hi : (raw < lo ? lo : raw);
  endfunction
endpackage

// File: rtl/pwm_ramp_ch.sv
// pwm_ramp_ch: one channel -- duty shadow, clamp, slew-limited width and registered compare
module pwm_ramp_ch
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned MIN_WIDTH = 160000,
  parameter int unsigned MAX_WIDTH = 360000,
  parameter int unsigned DUTY_W    = 8,
  parameter int unsigned STEP      = 20000,
  parameter int unsigned WW        = WIDTH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              duty_valid_i,
  input  logic              active_i,
  input  logic              boundary_i,
  input  logic              timeout_i,
  input  logic [WW-1:0]     count_i,
  output logic              pwm_o
);
  logic [DUTY_W+WW-1:0] prod;
  logic [WW-1:0] raw, tgt, eff, diff;
  logic [WW-1:0] shadow_q, shadow_d, applied_q, applied_d;
  logic pwm_q, pwm_d;
  always_comb begin
    prod = (DUTY_W+WW)'(duty_i) * (DUTY_W+WW)'(PERIOD);
    raw = prod[DUTY_W+WW-1:DUTY_W];
    tgt = WW'(clamp(32'(raw), MIN_WIDTH, MAX_WIDTH));
    shadow_d = duty_valid_i ? tgt : shadow_q;
    eff = timeout_i ? WW'(MIN_WIDTH) : shadow_q;
    diff = eff > applied_q ? eff - applied_q : applied_q - eff;
    // width only moves at the period boundary so a period is never cut short
    applied_d = !active_i ? WW'(MIN_WIDTH) :
                !boundary_i ? applied_q :
                32'(diff) <= STEP ? eff :
                eff > applied_q ? applied_q + WW'(STEP) : applied_q - WW'(STEP);
    pwm_d = active_i && count_i < applied_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= WW'(MIN_WIDTH);
      applied_q <= WW'(MIN_WIDTH);
      pwm_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      applied_q <= applied_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multi_ramp.sv
// pwm_multi_ramp: shared period counter, run/idle FSM and command watchdog driving NUM_CH ramped PWM channels
module pwm_multi_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned PERIOD       = DEF_PERIOD,
  parameter int unsigned MIN_WIDTH    = 160000,
  parameter int unsigned MAX_WIDTH    = 360000,
  parameter int unsigned DUTY_W       = 8,
  parameter int unsigned STEP         = 20000,
  parameter int unsigned WDOG_PERIODS = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NUM_CH*DUTY_W-1:0] duty,
  input  logic                     duty_valid,
  output logic [NUM_CH-1:0]        pwm,
  output logic                     period_start,
  output logic                     timeout
);
  localparam int unsigned WW = width_bits(PERIOD);
  localparam int unsigned DW = $clog2(WDOG_PERIODS + 2);
  if (!(MIN_WIDTH <= MAX_WIDTH && MAX_WIDTH < PERIOD && STEP >= 1)) begin : g_bad_params
    $error("pwm_multi_ramp: need MIN_WIDTH <= MAX_WIDTH < PERIOD and STEP >= 1");
  end
  state_e state_q, state_d;
  logic active, last, boundary;
  logic [WW-1:0] count_q, count_d;
  logic [DW-1:0] wd_q, wd_d;
  logic ps_q, ps_d, to_q, to_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (enable ? RUN : IDLE) : (enable ? RUN : IDLE);
  end
  always_comb begin
    active = state_q == RUN && enable;
    last = count_q == WW'(PERIOD - 1);
    boundary = active && last;
  end
  // a fresh period begins both on wrap and on leaving IDLE
  always_comb begin
    count_d = active && !last ? count_q + 1'b1 : '0;
    ps_d = enable && (state_q == IDLE || last);
    wd_d = duty_valid ? '0 : boundary && wd_q != DW'(WDOG_PERIODS) ? wd_q + 1'b1 : wd_q;
    to_d = !duty_valid && (to_q || wd_d == DW'(WDOG_PERIODS));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wd_q <= '0;
      ps_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wd_q <= wd_d;
      ps_q <= ps_d;
      to_q <= to_d;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_ramp_ch #(
      .PERIOD(PERIOD), .MIN_WIDTH(MIN_WIDTH), .MAX_WIDTH(MAX_WIDTH),
      .DUTY_W(DUTY_W), .STEP(STEP), .WW(WW)
    ) u_ch (
      .clk(clk), .rst_n(rst_n),
      .duty_i(duty[i*DUTY_W +: DUTY_W]), .duty_valid_i(duty_valid),
      .active_i(active), .boundary_i(boundary), .timeout_i(to_q),
      .count_i(count_q), .pwm_o(pwm[i])
    );
  end
  assign period_start = ps_q;
  assign timeout = to_q;
endmodule
